pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage MIPS pipeline. It watches the ID stage for load-use hazards, the EX stage for multi-cycle ALU operations (mult/div), and the exception logic for flush requests. It drives per-register hold and bubble controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It also keeps a saturating stall-cycle performance counter.

---
 rtl/pipeline_ctrl.sv | 118 +++++++++++
 tb/tb_pipeline_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline
//
// Purpose: detects load-use hazards, sequences multi-cycle EX ops and applies
// flush requests. It drives per-register hold (stall) and NOP-insert (bubble)
// controls and keeps a saturating count of PC-stall cycles.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   flush_req                flush request from MEM-stage exception logic
//   ex_multi_start/len       multi-cycle op starting in EX and its total length
//   ex_is_load, ex_write_or_not, ex_dest_addr   EX instruction info for hazard
//   id_rs, id_rt, id_rs_read, id_rt_read        ID source operands
//   stall[4:0]               hold: PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//   bubble[4:0]              register loads a NOP this cycle
//   flush                    clear IF/ID, ID/EX, EX/MEM at next edge
//   ex_busy, ex_done         multi-cycle op in progress / final cycle
//   stall_cycles             saturating count of cycles with stall[0]=1
module pipeline_ctrl #(
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_req,
  input  logic             ex_multi_start,
  input  logic [LEN_W-1:0] ex_multi_len,
  input  logic             ex_is_load,
  input  logic             ex_write_or_not,
  input  logic [4:0]       ex_dest_addr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_rs_read,
  input  logic             id_rt_read,
  output logic [4:0]       stall,
  output logic [4:0]       bubble,
  output logic             flush,
  output logic             ex_busy,
  output logic             ex_done,
  output logic [31:0]      stall_cycles
);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] EXBUSY = 1'b1;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  logic [0:0]       state, state_n;
  logic [LEN_W-1:0] cnt, cnt_n;
  logic             busy_q;
  logic [31:0]      stall_cnt;

  logic       hazard;
  logic [4:0] stall_c;
  logic       flush_c;
  logic       done_c;

  assign hazard = ex_is_load & ex_write_or_not & (ex_dest_addr != 5'd0) &
                  ((id_rs_read & (id_rs == ex_dest_addr)) |
                   (id_rt_read & (id_rt == ex_dest_addr)));

  always_comb begin
    stall_c = 5'b00000;
    flush_c = 1'b0;
    done_c  = 1'b0;
    state_n = state;
    cnt_n   = cnt;
    if (flush_req) begin
      flush_c = 1'b1;
      state_n = IDLE;
      cnt_n   = '0;
    end else if (state == EXBUSY) begin
      // Start requests and hazards are ignored while busy: the multi-cycle
      // stall already holds the ID instruction in place.
      if (cnt > ONE) begin
        stall_c = 5'b00111;
        cnt_n   = cnt - ONE;
      end else begin
        done_c  = 1'b1;
        state_n = IDLE;
        cnt_n   = '0;
      end
    end else if (ex_multi_start) begin
      if (ex_multi_len > ONE) begin
        stall_c = 5'b00111;
        cnt_n   = ex_multi_len - ONE;
        state_n = EXBUSY;
      end else begin
        done_c = 1'b1;
      end
    end else if (hazard) begin
      stall_c = 5'b00011;
    end
  end

  // Outputs are forced low for as long as reset is held, not just at edges.
  assign stall        = rst ? 5'b00000 : stall_c;
  assign bubble       = {stall[3:0] & ~stall[4:1], 1'b0};
  assign flush        = ~rst & flush_c;
  assign ex_done      = ~rst & done_c;
  assign ex_busy      = busy_q;
  assign stall_cycles = stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      busy_q    <= 1'b0;
      stall_cnt <= 32'd0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      busy_q <= (state_n == EXBUSY);
      if (stall_c[0] && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_req;
  logic        ex_multi_start;
  logic [3:0]  ex_multi_len;
  logic        ex_is_load;
  logic        ex_write_or_not;
  logic [4:0]  ex_dest_addr;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_rs_read;
  logic        id_rt_read;
  logic [4:0]  stall;
  logic [4:0]  bubble;
  logic        flush;
  logic        ex_busy;
  logic        ex_done;
  logic [31:0] stall_cycles;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl #(.LEN_W(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_req      (flush_req),
    .ex_multi_start (ex_multi_start),
    .ex_multi_len   (ex_multi_len),
    .ex_is_load     (ex_is_load),
    .ex_write_or_not(ex_write_or_not),
    .ex_dest_addr   (ex_dest_addr),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rs_read     (id_rs_read),
    .id_rt_read     (id_rt_read),
    .stall          (stall),
    .bubble         (bubble),
    .flush          (flush),
    .ex_busy        (ex_busy),
    .ex_done        (ex_done),
    .stall_cycles   (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk(input string tag, input logic [4:0] st, input logic [4:0] bb,
                     input logic fl, input logic dn, input logic bz);
    check({tag, ".stall"},   32'(stall),   32'(st));
    check({tag, ".bubble"},  32'(bubble),  32'(bb));
    check({tag, ".flush"},   32'(flush),   32'(fl));
    check({tag, ".ex_done"}, 32'(ex_done), 32'(dn));
    check({tag, ".ex_busy"}, 32'(ex_busy), 32'(bz));
  endtask

  task automatic clr();
    flush_req = 0; ex_multi_start = 0; ex_multi_len = 0;
    ex_is_load = 0; ex_write_or_not = 0; ex_dest_addr = 0;
    id_rs = 0; id_rt = 0; id_rs_read = 0; id_rt_read = 0;
  endtask

  task automatic haz(input logic [4:0] dest, input logic [4:0] rs, input logic rsr,
                     input logic [4:0] rt, input logic rtr);
    ex_is_load = 1; ex_write_or_not = 1; ex_dest_addr = dest;
    id_rs = rs; id_rs_read = rsr; id_rt = rt; id_rt_read = rtr;
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    cyc();
    // reset forces outputs low even with a hazard presented
    haz(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    #1;
    chk("reset", 5'b00000, 5'b00000, 0, 0, 0);
    check("reset.cycles", stall_cycles, 32'd0);
    cyc(); rst = 1'b0; clr(); #1;
    chk("idle", 5'b00000, 5'b00000, 0, 0, 0);

    // load-use via rs
    cyc(); haz(5'd5, 5'd5, 1'b1, 5'd0, 1'b0); #1;
    chk("lu_rs", 5'b00011, 5'b00100, 0, 0, 0);
    cyc(); clr(); #1;
    chk("lu_after", 5'b00000, 5'b00000, 0, 0, 0);
    check("lu.cycles", stall_cycles, 32'd1);
    cyc(); haz(5'd0, 5'd0, 1'b1, 5'd0, 1'b0); #1;
    chk("lu_r0", 5'b00000, 5'b00000, 0, 0, 0);
    cyc(); haz(5'd5, 5'd5, 1'b0, 5'd0, 1'b0); #1;
    chk("lu_noread", 5'b00000, 5'b00000, 0, 0, 0);
    cyc(); haz(5'd9, 5'd1, 1'b1, 5'd9, 1'b1); #1;
    chk("lu_rt", 5'b00011, 5'b00100, 0, 0, 0);
    cyc(); clr(); #1;
    check("lu_rt.cycles", stall_cycles, 32'd2);

    // multi-cycle len=5: 4 stall cycles then done
    cyc(); ex_multi_start = 1; ex_multi_len = 4'd5; #1;
    chk("m5_c1", 5'b00111, 5'b01000, 0, 0, 0);
    for (int i = 2; i <= 4; i++) begin
      cyc(); clr(); #1;
      chk($sformatf("m5_c%0d", i), 5'b00111, 5'b01000, 0, 0, 1);
    end
    cyc(); #1;
    chk("m5_c5", 5'b00000, 5'b00000, 0, 1, 1);
    cyc(); #1;
    chk("m5_c6", 5'b00000, 5'b00000, 0, 0, 0);
    check("m5.cycles", stall_cycles, 32'd6);

    // len=1 is a single-cycle op
    cyc(); ex_multi_start = 1; ex_multi_len = 4'd1; #1;
    chk("m1", 5'b00000, 5'b00000, 0, 1, 0);
    cyc(); clr(); #1;
    chk("m1_after", 5'b00000, 5'b00000, 0, 0, 0);
    check("m1.cycles", stall_cycles, 32'd6);

    // len=8 aborted by flush on the 3rd busy cycle
    cyc(); ex_multi_start = 1; ex_multi_len = 4'd8; #1;
    chk("ab_c1", 5'b00111, 5'b01000, 0, 0, 0);
    cyc(); clr(); #1;
    chk("ab_b1", 5'b00111, 5'b01000, 0, 0, 1);
    cyc(); #1;
    chk("ab_b2", 5'b00111, 5'b01000, 0, 0, 1);
    cyc(); flush_req = 1; #1;
    chk("ab_b3", 5'b00000, 5'b00000, 1, 0, 1);
    cyc(); clr(); #1;
    chk("ab_after", 5'b00000, 5'b00000, 0, 0, 0);
    check("ab.cycles", stall_cycles, 32'd9);

    // flush + start + hazard: flush only
    cyc(); haz(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    ex_multi_start = 1; ex_multi_len = 4'd3; flush_req = 1; #1;
    chk("pri_all", 5'b00000, 5'b00000, 1, 0, 0);
    cyc(); clr(); #1;
    chk("pri_all_after", 5'b00000, 5'b00000, 0, 0, 0);
    check("pri_all.cycles", stall_cycles, 32'd9);

    // start + hazard, hazard held through EXBUSY
    cyc(); haz(5'd3, 5'd3, 1'b1, 5'd0, 1'b0);
    ex_multi_start = 1; ex_multi_len = 4'd3; #1;
    chk("pri_sh_c1", 5'b00111, 5'b01000, 0, 0, 0);
    cyc(); ex_multi_start = 0; #1;
    chk("pri_sh_c2", 5'b00111, 5'b01000, 0, 0, 1);
    cyc(); #1;
    chk("pri_sh_c3", 5'b00000, 5'b00000, 0, 1, 1);
    cyc(); #1;
    chk("pri_sh_c4", 5'b00011, 5'b00100, 0, 0, 0);
    cyc(); clr(); #1;
    check("pri_sh.cycles", stall_cycles, 32'd12);

    // flush in the cnt==1 cycle suppresses ex_done
    cyc(); ex_multi_start = 1; ex_multi_len = 4'd2; #1;
    chk("fd_c1", 5'b00111, 5'b01000, 0, 0, 0);
    cyc(); clr(); flush_req = 1; #1;
    chk("fd_c2", 5'b00000, 5'b00000, 1, 0, 1);
    cyc(); clr(); #1;
    chk("fd_after", 5'b00000, 5'b00000, 0, 0, 0);
    check("fd.cycles", stall_cycles, 32'd13);

    // asynchronous reset mid-EXBUSY
    cyc(); ex_multi_start = 1; ex_multi_len = 4'd6; #1;
    cyc(); clr(); #1;
    chk("rs_busy", 5'b00111, 5'b01000, 0, 0, 1);
    #2; rst = 1'b1; #1;
    chk("rs_async", 5'b00000, 5'b00000, 0, 0, 0);
    check("rs.cycles", stall_cycles, 32'd0);
    cyc(); rst = 1'b0; #1;
    chk("rs_idle", 5'b00000, 5'b00000, 0, 0, 0);
    cyc(); haz(5'd7, 5'd0, 1'b0, 5'd7, 1'b1); #1;
    chk("rs_haz", 5'b00011, 5'b00100, 0, 0, 0);
    cyc(); clr(); #1;
    check("rs_haz.cycles", stall_cycles, 32'd1);

    // saturation
    force dut.stall_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.stall_cnt;
    cyc(); ex_multi_start = 1; ex_multi_len = 4'd4; #1;
    chk("sat_c1", 5'b00111, 5'b01000, 0, 0, 0);
    cyc(); clr(); #1;
    check("sat.first", stall_cycles, 32'hFFFF_FFFF);
    cyc(); #1;
    cyc(); #1;
    chk("sat_done", 5'b00000, 5'b00000, 0, 1, 1);
    check("sat.hold", stall_cycles, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
